// File: rtl/ldl_ram_p1_arb.sv
// Single-port RAM front end: arbitrates a write channel and a read-request channel
// onto one RAM port and returns read data through a 2-entry response FIFO.
module ldl_ram_p1_arb #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int ARB    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              ram_re,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout
);

    logic              en_q, en_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        rsp_cnt_q, rsp_cnt_d;
    logic              rr_last_wr_q, rr_last_wr_d;
    logic [DWIDTH-1:0] ent0_q, ent0_d;
    logic [DWIDTH-1:0] ent1_q, ent1_d;

    logic              pop;
    logic              push;
    logic [2:0]        occ;
    logic              rd_ok;
    logic              rd_req;
    logic              wr_req;
    logic              grant_wr;
    logic              grant_rd;
    logic [1:0]        wr_idx;

    // Grant: a read is only requested when its response is guaranteed a FIFO slot.
    always_comb begin
        pop      = (rsp_cnt_q != 2'd0) & rsp_ready;
        push     = inflight_q;
        occ      = {1'b0, rsp_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_ok    = (occ < 3'd2);
        rd_req   = rd_valid & rd_ok;
        wr_req   = wr_valid;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (en_q) begin
            if (wr_req && rd_req) begin
                if (ARB == 1) begin
                    grant_wr = 1'b1;
                end else if (ARB == 2) begin
                    grant_rd = 1'b1;
                end else if (rr_last_wr_q) begin
                    grant_rd = 1'b1;
                end else begin
                    grant_wr = 1'b1;
                end
            end else begin
                grant_wr = wr_req;
                grant_rd = rd_req;
            end
        end
    end

    always_comb begin
        en_d         = 1'b1;
        inflight_d   = grant_rd;
        rr_last_wr_d = rr_last_wr_q;
        if (grant_wr) begin
            rr_last_wr_d = 1'b1;
        end else if (grant_rd) begin
            rr_last_wr_d = 1'b0;
        end
        rsp_cnt_d = rsp_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // FIFO storage: head shifts on pop; the incoming word lands after the survivors.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        wr_idx = rsp_cnt_q - {1'b0, pop};
        if (pop) begin
            ent0_d = ent1_q;
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                ent0_d = ram_dout;
            end else begin
                ent1_d = ram_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            inflight_q   <= 1'b0;
            rsp_cnt_q    <= 2'd0;
            rr_last_wr_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            inflight_q   <= inflight_d;
            rsp_cnt_q    <= rsp_cnt_d;
            rr_last_wr_q <= rr_last_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign wr_ready  = grant_wr;
    assign ram_we    = grant_wr;
    assign rd_ready  = grant_rd;
    assign ram_re    = grant_rd;
    assign ram_addr  = grant_wr ? wr_addr : rd_addr;
    assign ram_din   = wr_data;
    assign rsp_valid = (rsp_cnt_q != 2'd0);
    assign rsp_data  = ent0_q;

    // rd_ok must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (rsp_cnt_q == 2'd2) && !pop));

endmodule

// File: tb/tb_ldl_ram_p1_arb.sv
// Bench for ldl_ram_p1_arb: RAM model, scoreboard of expected read responses and a
// transaction-level model of grants, response timing and FIFO occupancy.
module tb_ldl_ram_p1_arb;

    localparam int ARB_T = 0;

    logic       clk;
    logic       rst_n;
    logic       wr_valid, wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [3:0] rd_addr;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       ram_re, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    ldl_ram_p1_arb #(.DWIDTH(8), .AWIDTH(4), .ARB(ARB_T)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: 1-cycle read latency, dout holds while re=0; contents survive reset.
    logic [7:0] init_val [16];
    logic [7:0] mem [16];
    logic       loaded = 1'b0;
    initial ram_dout = 8'h00;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
            loaded <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            if (ram_re) ram_dout <= mem[ram_addr];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: no handshake within cycle budget (cycle %0d)", nm, cyc);
    endtask

    // Reference model: memory image, outstanding reads with accept cycle, arbitration history.
    typedef struct {
        logic [7:0] data;
        int         acc;
    } exp_t;
    exp_t       q[$];
    logic [7:0] ref_mem [16];
    bit         m_en = 1'b0;
    bit         m_last_wr = 1'b0;
    bit         e_wr, e_rd, e_pop, e_vld, ok, rd_req_m;
    exp_t       ent;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_en      = 1'b0;
            m_last_wr = 1'b0;
            q.delete();
            chk("rst_wr_ready", int'(wr_ready), 0);
            chk("rst_rd_ready", int'(rd_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
        end else begin
            e_vld    = (q.size() > 0) && (cyc >= q[0].acc + 2);
            e_pop    = e_vld && rsp_ready;
            ok       = (int'(q.size()) - int'(e_pop)) < 2;
            rd_req_m = rd_valid && ok;
            e_wr     = 1'b0;
            e_rd     = 1'b0;
            if (m_en) begin
                if (wr_valid && rd_req_m) begin
                    case (ARB_T)
                        1:       e_wr = 1'b1;
                        2:       e_rd = 1'b1;
                        default: if (m_last_wr) e_rd = 1'b1; else e_wr = 1'b1;
                    endcase
                end else begin
                    e_wr = wr_valid;
                    e_rd = rd_req_m;
                end
            end
            chk("wr_ready", int'(wr_ready), int'(e_wr));
            chk("rd_ready", int'(rd_ready), int'(e_rd));
            chk("ram_we", int'(ram_we), int'(e_wr));
            chk("ram_re", int'(ram_re), int'(e_rd));
            chk("rsp_valid", int'(rsp_valid), int'(e_vld));
            if (e_wr) begin
                chk("ram_addr_wr", int'(ram_addr), int'(wr_addr));
                chk("ram_din", int'(ram_din), int'(wr_data));
            end
            if (e_rd) chk("ram_addr_rd", int'(ram_addr), int'(rd_addr));
            if (e_pop) begin
                chk("rsp_data", int'(rsp_data), int'(q[0].data));
                void'(q.pop_front());
            end
            if (e_wr) begin
                ref_mem[wr_addr] = wr_data;
                m_last_wr = 1'b1;
            end
            if (e_rd) begin
                ent.data = ref_mem[rd_addr];
                ent.acc  = cyc;
                q.push_back(ent);
                m_last_wr = 1'b0;
            end
            m_en = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic wr_txn(input logic [3:0] a, input logic [7:0] d);
        int g;
        g = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) timeout_fail("wr_txn");
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd_txn(input logic [3:0] a, output int acc);
        int g;
        g = 0;
        rd_valid = 1'b1;
        rd_addr  = a;
        @(negedge clk);
        while (!rd_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) timeout_fail("rd_txn");
        acc = cyc;
        step();
        rd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int n;
        int g;
        logic [3:0] a;
        logic [7:0] d;

        for (int i = 0; i < 16; i++) begin
            init_val[i] = 8'($urandom);
            ref_mem[i]  = init_val[i];
        end
        rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = 4'h0; wr_data = 8'h00; rd_addr = 4'h0; rsp_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("release_wr_ready", int'(wr_ready), 0);
        chk("release_rd_ready", int'(rd_ready), 0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        step();

        // T1: write then read back with fixed 2-cycle response latency.
        wr_txn(4'h3, 8'hA5);
        rd_txn(4'h3, acc);
        while (cyc < acc + 2) @(negedge clk);
        chk("t1_rsp_valid", int'(rsp_valid), 1);
        chk("t1_rsp_data", int'(rsp_data), 8'hA5);
        step();

        // T2: contention after a read grant alternates W,R,W,R,W,R.
        wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_addr = 4'($urandom); wr_data = 8'($urandom); rd_addr = 4'($urandom);
            @(negedge clk);
            chk("t2_wr_grant", int'(wr_ready), (k % 2 == 0) ? 1 : 0);
            chk("t2_rd_grant", int'(rd_ready), (k % 2 == 1) ? 1 : 0);
            step();
        end
        idle(4);

        // T3: backpressure admits exactly two reads; writes still pass; reads resume at once.
        rsp_ready = 1'b0; rd_valid = 1'b1; n = 0;
        for (int k = 0; k < 6; k++) begin
            rd_addr  = 4'($urandom);
            wr_valid = (k >= 3);
            wr_addr  = 4'($urandom); wr_data = 8'($urandom);
            @(negedge clk);
            if (rd_ready) n++;
            if (k >= 3) chk("t3_wr_during_bp", int'(wr_ready), 1);
            step();
        end
        chk("t3_accepts", n, 2);
        wr_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume", int'(rd_ready), 1);
        step();
        idle(4);

        // T4: reads of 0..15 back to back, one per cycle.
        rsp_ready = 1'b1; rd_valid = 1'b1; a = 4'h0; n = 0; g = 0;
        rd_addr = a;
        while (n < 16 && g < 60) begin
            @(negedge clk);
            if (rd_ready) begin
                n++;
                a = a + 4'h1;
            end
            g++;
            step();
            rd_addr = a;
        end
        rd_valid = 1'b0;
        if (n < 16) timeout_fail("t4_reads");
        chk("t4_cycles", g, 16);
        idle(4);

        // T5: same-address write then read in consecutive cycles.
        d = 8'($urandom);
        wr_txn(4'h7, d);
        rd_txn(4'h7, acc);
        while (cyc < acc + 2) @(negedge clk);
        chk("t5_rsp_data", int'(rsp_data), int'(d));
        step();

        // Random traffic with random consumer stalls.
        for (int k = 0; k < 400; k++) begin
            wr_valid  = 1'($urandom);
            rd_valid  = 1'($urandom);
            wr_addr   = 4'($urandom);
            wr_data   = 8'($urandom);
            rd_addr   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(6);

        // T6: reset with one read in flight and one response buffered.
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 4'($urandom);
        step();
        rd_addr = 4'($urandom);
        step();
        rd_valid = 1'b0;
        chk("t6_pre_rsp_valid", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid_async", int'(rsp_valid), 0);
        chk("t6_rd_ready_async", int'(rd_ready), 0);
        step();
        step();
        rst_n = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
        wr_addr = 4'($urandom); wr_data = 8'($urandom); rd_addr = 4'($urandom);
        #1;
        chk("t6_wr_ready_after_release", int'(wr_ready), 0);
        chk("t6_rd_ready_after_release", int'(rd_ready), 0);
        step();
        for (int k = 0; k < 40; k++) begin
            wr_valid  = 1'($urandom);
            rd_valid  = 1'($urandom);
            wr_addr   = 4'($urandom);
            wr_data   = 8'($urandom);
            rd_addr   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
